// File: rtl/mstage_lsu.sv
// Memory-access stage: takes one E-stage instruction, runs its load/store over
// AXI4-Lite, then hands aligned load data, error flag and pass-through bundle to W.
module mstage_lsu #(
  parameter int PT_W = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            memrdE,
  input  logic            memwrE,
  input  logic [2:0]      funct3E,
  input  logic [31:0]     ALU_resultE,
  input  logic [31:0]     src2E,
  input  logic [PT_W-1:0] ptE,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [31:0]     mdataM,
  output logic [31:0]     ALU_resultM,
  output logic            memerrM,
  output logic [PT_W-1:0] ptM,
  output logic [31:0]     araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic [31:0]     awaddr,
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wvalid,
  input  logic            wready,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} state_t;

  state_t      state, state_nx;
  logic        rd_q, wr_q;
  logic [2:0]  f3_q;
  logic [31:0] src2_q;
  logic        aw_done, w_done;
  logic        accept;
  logic        misalign_e;
  logic        aw_fire, w_fire, both_done;
  logic [31:0] lane;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic [3:0]  store_strb;

  assign accept = s_valid & s_ready;

  // funct3[1:0]: 00 byte, 01 half, otherwise word
  assign misalign_e = ((funct3E[1:0] == 2'b01) && ALU_resultE[0]) ||
                      (funct3E[1] && (ALU_resultE[1:0] != 2'b00));

  assign aw_fire   = awvalid & awready;
  assign w_fire    = wvalid & wready;
  assign both_done = (aw_done | aw_fire) & (w_done | w_fire);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    arvalid  = 1'b0;
    rready   = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (!(memrdE | memwrE) || misalign_e) state_nx = DONE;
          else if (memrdE)                      state_nx = AR;
          else                                  state_nx = WR;
        end
      end
      AR: begin
        arvalid = rd_q;
        if (arready) state_nx = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_nx = DONE;
      end
      WR: begin
        awvalid = wr_q & ~aw_done;
        wvalid  = wr_q & ~w_done;
        if (both_done) state_nx = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_nx = DONE;
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Load lane select and extension; bit 2 of funct3 marks the unsigned forms
  assign lane = rdata >> {ALU_resultM[1:0], 3'b000};

  always_comb begin
    load_data = rdata;
    case (f3_q[1:0])
      2'b00:   load_data = f3_q[2] ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_data = f3_q[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    store_data = src2_q;
    store_strb = 4'b1111;
    case (f3_q[1:0])
      2'b00: begin
        store_data = {4{src2_q[7:0]}};
        store_strb = 4'b0001 << ALU_resultM[1:0];
      end
      2'b01: begin
        store_data = {2{src2_q[15:0]}};
        store_strb = 4'b0011 << ALU_resultM[1:0];
      end
      default: begin
        store_data = src2_q;
        store_strb = 4'b1111;
      end
    endcase
  end

  assign araddr = {ALU_resultM[31:2], 2'b00};
  assign awaddr = {ALU_resultM[31:2], 2'b00};
  assign wdata  = store_data;
  assign wstrb  = (state == WR && wr_q) ? store_strb : 4'b0000;

  // Datapath registers; a misaligned memory access is flagged at accept and never reaches the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      f3_q        <= 3'b000;
      src2_q      <= 32'b0;
      ALU_resultM <= 32'b0;
      ptM         <= '0;
      mdataM      <= 32'b0;
      memerrM     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      if (accept) begin
        rd_q        <= memrdE;
        wr_q        <= memwrE;
        f3_q        <= funct3E;
        src2_q      <= src2E;
        ALU_resultM <= ALU_resultE;
        ptM         <= ptE;
        mdataM      <= 32'b0;
        memerrM     <= (memrdE | memwrE) & misalign_e;
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
      end
      if (state == R && rvalid) begin
        mdataM <= rd_q ? load_data : 32'b0;
        if (rresp != 2'b00) memerrM <= 1'b1;
      end
      if (state == WR) begin
        if (both_done) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
      end
      if (state == B && bvalid && bresp != 2'b00) memerrM <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mstage_lsu.sv
// Self-checking bench for mstage_lsu: directed vector table, randomized
// transactions against a size/offset reference model, and reset-mid-read.
module tb_mstage_lsu;
  localparam int PT_W = 256;

  logic            clk, rst;
  logic            s_valid, s_ready;
  logic            memrdE, memwrE;
  logic [2:0]      funct3E;
  logic [31:0]     ALU_resultE, src2E;
  logic [PT_W-1:0] ptE;
  logic            m_valid, m_ready;
  logic [31:0]     mdataM, ALU_resultM;
  logic            memerrM;
  logic [PT_W-1:0] ptM;
  logic [31:0]     araddr;
  logic            arvalid, arready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rvalid, rready;
  logic [31:0]     awaddr;
  logic            awvalid, awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;

  mstage_lsu #(.PT_W(PT_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .memrdE(memrdE), .memwrE(memwrE), .funct3E(funct3E),
    .ALU_resultE(ALU_resultE), .src2E(src2E), .ptE(ptE),
    .m_valid(m_valid), .m_ready(m_ready),
    .mdataM(mdataM), .ALU_resultM(ALU_resultM), .memerrM(memerrM), .ptM(ptM),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bus: 0 no transaction, 1 read, 2 write
  typedef struct {
    logic            rd;
    logic            wr;
    logic [2:0]      f3;
    logic [31:0]     addr;
    logic [31:0]     src2;
    logic [31:0]     rdata;
    logic [1:0]      resp;
    logic [PT_W-1:0] pt;
    int              bus;
    logic [31:0]     exp_mdata;
    logic            exp_err;
    logic [31:0]     exp_araddr;
    logic [31:0]     exp_wdata;
    logic [3:0]      exp_wstrb;
    int              ar_dly, r_dly, aw_dly, w_dly, b_dly, m_dly;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkWide(input string name, input logic [PT_W-1:0] act, input logic [PT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] src2,
                              input logic [31:0] rd_data, input logic [1:0] resp, input int bus,
                              input logic [31:0] emd, input logic eerr, input logic [31:0] ear,
                              input logic [31:0] ewd, input logic [3:0] ews);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.src2 = src2;
    v.rdata = rd_data; v.resp = resp; v.pt = '0; v.bus = bus;
    v.exp_mdata = emd; v.exp_err = eerr; v.exp_araddr = ear;
    v.exp_wdata = ewd; v.exp_wstrb = ews;
    v.ar_dly = 0; v.r_dly = 0; v.aw_dly = 0; v.w_dly = 0; v.b_dly = 0; v.m_dly = 0;
    return v;
  endfunction

  // Reference model: access size in bytes, byte offset, and plain arithmetic on lanes
  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    int sz, off;
    logic [31:0] lane_v;
    sz  = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
    off = int'(v.addr % 4);
    o.exp_mdata  = 32'd0;
    o.exp_err    = 1'b0;
    o.exp_araddr = v.addr - (v.addr % 4);
    o.exp_wdata  = 32'd0;
    o.exp_wstrb  = 4'd0;
    o.bus        = 0;
    if (v.rd || v.wr) begin
      if ((v.addr % sz) != 0) o.exp_err = 1'b1;
      else begin
        o.bus     = v.rd ? 1 : 2;
        o.exp_err = (v.resp != 2'b00);
      end
    end
    if (o.bus == 1) begin
      lane_v = v.rdata / (32'd1 << (8 * off));
      if (sz == 1) begin
        lane_v = lane_v % 256;
        if (!v.f3[2] && lane_v >= 128) lane_v = lane_v - 32'd256;
      end else if (sz == 2) begin
        lane_v = lane_v % 65536;
        if (!v.f3[2] && lane_v >= 32768) lane_v = lane_v - 32'd65536;
      end
      o.exp_mdata = lane_v;
    end
    if (o.bus == 2) begin
      if (sz == 1)      o.exp_wdata = (v.src2 % 256) * 32'h01010101;
      else if (sz == 2) o.exp_wdata = (v.src2 % 65536) * 32'h00010001;
      else              o.exp_wdata = v.src2;
      o.exp_wstrb = 4'(((1 << sz) - 1) << off);
    end
    return o;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "_valids"}, {28'd0, arvalid, awvalid, wvalid, 1'b0}, 32'd0);
    checkOutput({tag, "_readys"}, {30'd0, rready, bready}, 32'd0);
    checkOutput({tag, "_mdataM"}, mdataM, 32'd0);
    checkOutput({tag, "_memerrM"}, 32'(memerrM), 32'd0);
    checkOutput({tag, "_ALU_resultM"}, ALU_resultM, 32'd0);
    checkWide({tag, "_ptM"}, ptM, '0);
    checkOutput({tag, "_araddr"}, araddr, 32'd0);
    checkOutput({tag, "_wdata"}, wdata, 32'd0);
    checkOutput({tag, "_wstrb"}, 32'(wstrb), 32'd0);
  endtask

  // Offer one instruction, play the AXI slave with the vector's delays, then drain DONE
  task automatic applyStimulus(input vec_t v);
    int  n;
    bit  aw_seen, w_seen;
    @(negedge clk);
    s_valid = 1'b1; memrdE = v.rd; memwrE = v.wr; funct3E = v.f3;
    ALU_resultE = v.addr; src2E = v.src2; ptE = v.pt;
    checkOutput("s_ready_idle", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0; memrdE = 1'($urandom); memwrE = 1'b0; funct3E = 3'($urandom);
    ALU_resultE = $urandom; src2E = $urandom; ptE = {8{$urandom}};
    if (v.bus == 1) begin
      for (n = 0; n <= v.ar_dly; n++) begin
        checkOutput("arvalid", 32'(arvalid), 32'd1);
        checkOutput("araddr", araddr, v.exp_araddr);
        arready = (n == v.ar_dly);
        @(negedge clk);
      end
      arready = 1'b0;
      for (n = 0; n <= v.r_dly; n++) begin
        checkOutput("rready", 32'(rready), 32'd1);
        checkOutput("arvalid_in_r", 32'(arvalid), 32'd0);
        rvalid = (n == v.r_dly); rdata = v.rdata; rresp = v.resp;
        @(negedge clk);
      end
      rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
    end else if (v.bus == 2) begin
      aw_seen = 1'b0; w_seen = 1'b0; n = 0;
      while (!(aw_seen && w_seen) && n < 40) begin
        checkOutput("awvalid", 32'(awvalid), 32'(!aw_seen));
        checkOutput("wvalid", 32'(wvalid), 32'(!w_seen));
        if (!aw_seen) checkOutput("awaddr", awaddr, v.exp_araddr);
        if (!w_seen) begin
          checkOutput("wdata", wdata, v.exp_wdata);
          checkOutput("wstrb", 32'(wstrb), 32'(v.exp_wstrb));
        end
        awready = !aw_seen && (n >= v.aw_dly);
        wready  = !w_seen && (n >= v.w_dly);
        @(negedge clk);
        if (awready) aw_seen = 1'b1;
        if (wready)  w_seen  = 1'b1;
        awready = 1'b0; wready = 1'b0; n++;
      end
      for (n = 0; n <= v.b_dly; n++) begin
        checkOutput("bready", 32'(bready), 32'd1);
        bvalid = (n == v.b_dly); bresp = v.resp;
        @(negedge clk);
      end
      bvalid = 1'b0; bresp = 2'($urandom);
    end
    for (n = 0; n <= v.m_dly; n++) begin
      checkOutput("m_valid", 32'(m_valid), 32'd1);
      checkOutput("s_ready_busy", 32'(s_ready), 32'd0);
      checkOutput("mdataM", mdataM, v.exp_mdata);
      checkOutput("memerrM", 32'(memerrM), 32'(v.exp_err));
      checkOutput("ALU_resultM", ALU_resultM, v.addr);
      checkWide("ptM", ptM, v.pt);
      checkOutput("axi_valids_done", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
      m_ready = (n == v.m_dly);
      @(negedge clk);
    end
    m_ready = 1'b0;
    checkOutput("m_valid_drop", 32'(m_valid), 32'd0);
    checkOutput("s_ready_back", 32'(s_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; s_valid = 1'b0; memrdE = 1'b0; memwrE = 1'b0; funct3E = 3'd0;
    ALU_resultE = 32'd0; src2E = 32'd0; ptE = '0; m_ready = 1'b0;
    arready = 1'b0; rdata = 32'd0; rresp = 2'd0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'd0; bvalid = 1'b0;

    tbl[0]  = mk(0, 0, 3'b000, 32'h12345678, 32'h0,        32'h0,        2'd0, 0, 32'h0,        0, 32'h0,        32'h0,        4'h0);
    tbl[1]  = mk(1, 0, 3'b000, 32'h80000003, 32'h0,        32'h80FF1234, 2'd0, 1, 32'hFFFFFF80, 0, 32'h80000000, 32'h0,        4'h0);
    tbl[2]  = mk(1, 0, 3'b100, 32'h80000003, 32'h0,        32'h80FF1234, 2'd0, 1, 32'h00000080, 0, 32'h80000000, 32'h0,        4'h0);
    tbl[3]  = mk(1, 0, 3'b101, 32'h80000002, 32'h0,        32'h80FF1234, 2'd0, 1, 32'h000080FF, 0, 32'h80000000, 32'h0,        4'h0);
    tbl[4]  = mk(1, 0, 3'b001, 32'h80000002, 32'h0,        32'h80FF1234, 2'd0, 1, 32'hFFFF80FF, 0, 32'h80000000, 32'h0,        4'h0);
    tbl[5]  = mk(1, 0, 3'b010, 32'h80000000, 32'h0,        32'hDEADBEEF, 2'd0, 1, 32'hDEADBEEF, 0, 32'h80000000, 32'h0,        4'h0);
    tbl[6]  = mk(1, 0, 3'b010, 32'h80000001, 32'h0,        32'h0,        2'd0, 0, 32'h0,        1, 32'h0,        32'h0,        4'h0);
    tbl[7]  = mk(1, 0, 3'b000, 32'h80000001, 32'h0,        32'h80FF1234, 2'd0, 1, 32'h00000012, 0, 32'h80000000, 32'h0,        4'h0);
    tbl[8]  = mk(1, 0, 3'b010, 32'h80000004, 32'h0,        32'h11223344, 2'd2, 1, 32'h11223344, 1, 32'h80000004, 32'h0,        4'h0);
    tbl[9]  = mk(0, 1, 3'b001, 32'h80000002, 32'h0000BEEF, 32'h0,        2'd0, 2, 32'h0,        0, 32'h80000000, 32'hBEEFBEEF, 4'b1100);
    tbl[10] = mk(0, 1, 3'b010, 32'h80000010, 32'hCAFEF00D, 32'h0,        2'd2, 2, 32'h0,        1, 32'h80000010, 32'hCAFEF00D, 4'b1111);
    tbl[11] = mk(0, 1, 3'b000, 32'h80000001, 32'h123456A5, 32'h0,        2'd0, 2, 32'h0,        0, 32'h80000000, 32'hA5A5A5A5, 4'b0010);
    tbl[12] = mk(0, 1, 3'b001, 32'h80000001, 32'h0000BEEF, 32'h0,        2'd0, 0, 32'h0,        1, 32'h0,        32'h0,        4'h0);
    tbl[13] = mk(1, 0, 3'b101, 32'h80000000, 32'h0,        32'h80FF1234, 2'd0, 1, 32'h00001234, 0, 32'h80000000, 32'h0,        4'h0);
    tbl[9].aw_dly = 0; tbl[9].w_dly = 3; tbl[9].b_dly = 1;
    tbl[1].m_dly  = 5;
    tbl[5].ar_dly = 2; tbl[5].r_dly = 3;
    tbl[11].aw_dly = 2; tbl[11].w_dly = 0;

    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      tbl[i].pt = {8{32'hA5000000 + 32'(i)}};
      applyStimulus(tbl[i]);
    end

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      v = mk(kind == 1, kind == 2, 3'b000, $urandom, $urandom, $urandom, 2'd0, 0,
             32'h0, 0, 32'h0, 32'h0, 4'h0);
      if (kind == 1) begin
        case ($urandom_range(0, 4))
          0: v.f3 = 3'b000;
          1: v.f3 = 3'b001;
          2: v.f3 = 3'b010;
          3: v.f3 = 3'b100;
          default: v.f3 = 3'b101;
        endcase
      end else begin
        v.f3 = 3'($urandom_range(0, 2));
      end
      v.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      v.pt = {8{$urandom}};
      v.ar_dly = int'($urandom_range(0, 3)); v.r_dly = int'($urandom_range(0, 3));
      v.aw_dly = int'($urandom_range(0, 3)); v.w_dly = int'($urandom_range(0, 3));
      v.b_dly  = int'($urandom_range(0, 3)); v.m_dly = int'($urandom_range(0, 3));
      applyStimulus(model(v));
    end

    // Reset while a read response is pending in R
    @(negedge clk);
    s_valid = 1'b1; memrdE = 1'b1; memwrE = 1'b0; funct3E = 3'b010;
    ALU_resultE = 32'h80000008; src2E = 32'h0; ptE = {8{32'h5A5A5A5A}};
    @(negedge clk);
    s_valid = 1'b0; memrdE = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    checkOutput("rst_mid_rready", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = 32'hFFFFFFFF; rresp = 2'd2; rst = 1'b1;
    @(negedge clk);
    checkResetState("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rvalid_ignored_mdata", mdataM, 32'd0);
    checkOutput("rvalid_ignored_err", 32'(memerrM), 32'd0);
    checkOutput("rvalid_ignored_rready", 32'(rready), 32'd0);
    rvalid = 1'b0;

    v = mk(0, 0, 3'b010, 32'h00000040, 32'h0, 32'h0, 2'd0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    v.pt = {8{32'h0BADF00D}};
    applyStimulus(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mstage_lsu.md
Name: mstage_lsu

Overview:
- Memory-access (M) stage of the NPC pipeline. It sits between the E stage and the M→W pipeline register.
- Accepts one E-stage instruction at a time and performs any load or store over an AXI4-Lite master port.
- Aligns and extends load data, then presents mdataM, a mem error flag and the untouched pass-through bundle to the W-side bus with a valid/ready handshake.

Parameters:
- PT_W, 256: width of the opaque pass-through bundle (pc, snpc, dnpc, rd, csr fields, etc.), copied unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_valid  in  1  E stage offers an instruction
- s_ready  out  1  block can accept an instruction
- memrdE  in  1  instruction is a load
- memwrE  in  1  instruction is a store (memrdE and memwrE are never both 1)
- funct3E  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALU_resultE  in  32  effective address
- src2E  in  32  store data
- ptE  in  PT_W  pass-through bundle
- m_valid  out  1  result valid toward the W bus
- m_ready  in  1  W bus accepts the result
- mdataM  out  32  aligned, extended load data (0 for non-loads)
- ALU_resultM  out  32  latched address
- memerrM  out  1  misaligned access or non-OKAY response
- ptM  out  PT_W  latched pass-through bundle
- araddr  out  32  AXI-Lite read address channel
- arvalid  out  1  AXI-Lite read address channel
- arready  in  1  AXI-Lite read address channel
- rdata  in  32  AXI-Lite read data channel
- rresp  in  2  AXI-Lite read data channel
- rvalid  in  1  AXI-Lite read data channel
- rready  out  1  AXI-Lite read data channel
- awaddr  out  32  AXI-Lite write address channel
- awvalid  out  1  AXI-Lite write address channel
- awready  in  1  AXI-Lite write address channel
- wdata  out  32  AXI-Lite write data channel
- wstrb  out  4  AXI-Lite write data channel
- wvalid  out  1  AXI-Lite write data channel
- wready  in  1  AXI-Lite write data channel
- bresp  in  2  AXI-Lite write response channel
- bvalid  in  1  AXI-Lite write response channel
- bready  out  1  AXI-Lite write response channel

Behaviour:
- FSM states: IDLE, AR, R, WR, B, DONE. Reset → IDLE.
- After reset all registered outputs are 0, and every valid/ready output is 0 except s_ready, which is 1.
- s_ready = (state==IDLE). m_valid = (state==DONE).
- There is no combinational path from s_valid to m_valid, or from m_ready to s_ready.
- Accept (s_valid & s_ready):
  - latch memrdE, memwrE, funct3E, ALU_resultE, src2E and ptE;
  - clear memerrM and mdataM.
- Misalignment check at accept: H with addr[0]!=0, or W with addr[1:0]!=0.
  - Misaligned load/store: memerrM<=1, no bus transaction, next state DONE.
  - Non-memory instruction: next state DONE.
  - Aligned load: next state AR. Aligned store: next state WR.
- AR state:
  - arvalid=1, araddr = {addr[31:2],2'b00};
  - on arready → R. araddr is held stable while arvalid=1.
- R state:
  - rready=1; on rvalid, capture the lane selected by addr[1:0] and → DONE;
  - B/H results are sign-extended, BU/HU zero-extended, W taken as-is;
  - rresp!=0 sets memerrM=1 (data still captured).
- WR state:
  - awvalid and wvalid are asserted together; each deasserts independently once its own ready is seen, tracked by aw_done and w_done flags;
  - both handshakes may complete in the same cycle or in any order;
  - when both are done → B;
  - awaddr = {addr[31:2],2'b00};
  - wdata replicates the store data: B → {4{src2[7:0]}}, H → {2{src2[15:0]}}, W → src2;
  - wstrb: B → 4'b0001<<addr[1:0], H → 4'b0011<<addr[1:0], W → 4'b1111.
- B state:
  - bready=1; on bvalid → DONE;
  - bresp!=0 sets memerrM=1.
- DONE state:
  - outputs held stable while m_valid=1;
  - on m_ready → IDLE. The next instruction can be accepted no earlier than the cycle after.
- Latency:
  - non-memory: accept at edge N, m_valid high during cycle N+1;
  - load with arready=1 and rvalid one cycle later: m_valid in cycle N+3.
- Reset mid-transaction: FSM → IDLE and all AXI valid/ready outputs drop the next cycle. The outstanding transaction is abandoned; the slave is reset together with the block.
- rvalid/bvalid outside R/B states are ignored (rready/bready are 0).

Test Plan:
- Non-mem: s_valid with memrdE=memwrE=0, ptE=pattern → m_valid in cycle after accept, ptM=pattern, mdataM=0, memerrM=0, no AXI valids asserted.
- LB at addr 0x80000003, rdata=0x80FF1234 → araddr 0x80000000, mdataM=0xFFFFFF80. Same access as LBU → 0x00000080. LHU at 0x80000002 → 0x000080FF.
- SH at 0x80000002, src2=0x0000BEEF, awready before wready by 3 cycles → awvalid and wvalid each drop after their own handshake, wdata=0xBEEFBEEF, wstrb=4'b1100, B handshake, then m_valid.
- LW at 0x80000001 → no arvalid, m_valid next cycle with memerrM=1. Separately, SW with bresp=2'b10 → memerrM=1.
- Backpressure: m_ready=0 for 5 cycles in DONE → m_valid, mdataM and ptM stable; s_ready=0 throughout; acceptance resumes after m_ready.
- Reset asserted while in R state with rvalid pending → next cycle state IDLE, s_ready=1, m_valid=0, rready=0, and all outputs at their reset values.
